// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: per-latch enables/flushes, PC write
// enable, load-use bubbles, data-memory wait, halt and a stall-cycle counter.
module hazard_ctrl #(
    parameter int NLATCH      = 4,
    parameter int LU_BUBBLES  = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              exmem_dreq,
    input  logic              idex_dread,
    input  logic [REG_W-1:0]  idex_rd,
    input  logic [REG_W-1:0]  ifid_rs,
    input  logic [REG_W-1:0]  ifid_rt,
    input  logic              npc_change,
    input  logic              idex_halt,
    input  logic              wb_halt,
    output logic [NLATCH-1:0] stage_en,
    output logic [NLATCH-1:0] stage_flush,
    output logic              pc_wen,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        DMEM_WAIT = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam logic [3:0] LP_LOAD = 4'(LU_BUBBLES - 1);
    localparam logic [NLATCH-1:0] LP_RDMASK =
        {NLATCH{1'b1}} >> (NLATCH - FLUSH_DEPTH);
    localparam logic [CNT_W-1:0] LP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            r_saved;
    logic   [3:0]      r_bub;
    logic   [CNT_W-1:0] r_cnt;

    state_t            w_next;
    state_t            w_saved_nxt;
    state_t            w_eff;
    logic   [3:0]      w_bub_nxt;
    logic   [NLATCH-1:0] w_en;
    logic   [NLATCH-1:0] w_fl;
    logic              w_pc;
    logic              w_lu;
    logic              w_freeze;

    assign w_lu = idex_dread && (idex_rd != '0) &&
                  ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

    // A miss, or an ongoing wait without dhit, freezes the whole pipe
    assign w_freeze = (exmem_dreq && !dhit) ||
                      ((r_state == DMEM_WAIT) && !dhit);

    // While waiting on memory the saved state decides what happens on dhit
    assign w_eff = (r_state == DMEM_WAIT) ? r_saved : r_state;

    // Prioritised next-state and latch control decode
    always_comb begin
        w_en        = '1;
        w_fl        = '0;
        w_pc        = 1'b1;
        w_next      = r_state;
        w_saved_nxt = r_saved;
        w_bub_nxt   = r_bub;
        if (r_state == HALTED) begin
            w_en = '0;
            w_pc = 1'b0;
        end else if (w_freeze) begin
            w_en   = '0;
            w_pc   = 1'b0;
            w_next = DMEM_WAIT;
            if (r_state != DMEM_WAIT) begin
                w_saved_nxt = r_state;
            end
        end else if (wb_halt) begin
            w_pc   = 1'b0;
            w_next = HALTED;
        end else if (npc_change) begin
            w_fl        = LP_RDMASK;
            w_fl[0]     = 1'b1;
            w_next      = RUN;
            w_saved_nxt = RUN;
            w_bub_nxt   = '0;
        end else if (w_eff == LU_STALL) begin
            w_en[0]   = 1'b0;
            w_fl[1]   = 1'b1;
            w_pc      = 1'b0;
            w_bub_nxt = r_bub - 4'd1;
            w_next    = (r_bub == 4'd1) ? RUN : LU_STALL;
        end else if (w_lu) begin
            w_en[0]   = 1'b0;
            w_fl[1]   = 1'b1;
            w_pc      = 1'b0;
            w_bub_nxt = LP_LOAD;
            w_next    = (LP_LOAD != 4'd0) ? LU_STALL : RUN;
        end else if (idex_halt || !ihit) begin
            w_fl[0] = 1'b1;
            w_pc    = 1'b0;
            w_next  = RUN;
        end else begin
            w_next = RUN;
        end
    end

    // Reset forces every latch to capture a bubble and holds the PC
    assign stage_en    = RST ? '1 : w_en;
    assign stage_flush = RST ? '1 : w_fl;
    assign pc_wen      = RST ? 1'b0 : w_pc;
    assign halted      = !RST && (r_state == HALTED);
    assign stall_cnt   = r_cnt;

    // State, saved state, bubble counter and saturating stall counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
            r_saved <= RUN;
            r_bub   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_saved <= w_saved_nxt;
            r_bub   <= w_bub_nxt;
            if (!w_pc && (r_state != HALTED) && (w_next != HALTED) &&
                (r_cnt != '1)) begin
                r_cnt <= r_cnt + LP_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a cycle model
// built from the priority rules (stall budget, wait flag, halt flag).
module tb_hazard_ctrl;

    localparam int NL   = 4;
    localparam int LUB  = 3;
    localparam int FD   = 2;
    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ihit, dhit, exmem_dreq, idex_dread;
    logic [RW-1:0] idex_rd, ifid_rs, ifid_rt;
    logic          npc_change, idex_halt, wb_halt;
    logic [NL-1:0] stage_en, stage_flush;
    logic          pc_wen, halted;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // model state: halted flag, waiting flag, bubbles still owed, counter
    int m_halted, m_wait, m_pend, m_cnt;
    int n_halted, n_wait, n_pend, n_cnt;

    hazard_ctrl #(
        .NLATCH(NL), .LU_BUBBLES(LUB), .FLUSH_DEPTH(FD),
        .REG_W(RW), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .exmem_dreq(exmem_dreq), .idex_dread(idex_dread),
        .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .npc_change(npc_change), .idex_halt(idex_halt),
        .wb_halt(wb_halt), .stage_en(stage_en),
        .stage_flush(stage_flush), .pc_wen(pc_wen),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Let inputs settle, predict outputs from the model and compare
    task automatic settle();
        logic [NL-1:0] e_en, e_fl;
        logic          e_pc, e_h;
        bit            lu, inc;
        #1;
        lu = idex_dread && (idex_rd != 0) &&
             ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
        e_en = '1; e_fl = '0; e_pc = 1'b1; e_h = 1'b0; inc = 0;
        n_halted = m_halted; n_wait = m_wait;
        n_pend = m_pend; n_cnt = m_cnt;
        if (RST) begin
            e_fl = '1; e_pc = 1'b0;
            n_halted = 0; n_wait = 0; n_pend = 0; n_cnt = 0;
        end else if (m_halted != 0) begin
            e_en = '0; e_pc = 1'b0; e_h = 1'b1;
        end else if ((exmem_dreq && !dhit) || (m_wait != 0 && !dhit)) begin
            e_en = '0; e_pc = 1'b0; n_wait = 1; inc = 1;
        end else begin
            n_wait = 0;
            if (wb_halt) begin
                e_pc = 1'b0; n_halted = 1;
            end else if (npc_change) begin
                e_fl = NL'((1 << FD) - 1) | NL'(!ihit);
                n_pend = 0;
            end else if (m_pend > 0 || lu) begin
                e_en = 4'b1110; e_fl = 4'b0010; e_pc = 1'b0; inc = 1;
                n_pend = ((m_pend > 0) ? m_pend : LUB) - 1;
            end else if (idex_halt || !ihit) begin
                e_fl = 4'b0001; e_pc = 1'b0; inc = 1;
            end
        end
        if (inc && m_cnt < CMAX) n_cnt = m_cnt + 1;
        chk("en", 32'(stage_en), 32'(e_en));
        chk("flush", 32'(stage_flush), 32'(e_fl));
        chk("pc_wen", 32'(pc_wen), 32'(e_pc));
        chk("halted", 32'(halted), 32'(e_h));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge CLK);
        m_halted = n_halted; m_wait = n_wait;
        m_pend = n_pend; m_cnt = n_cnt;
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b1; dhit = 1'b1; exmem_dreq = 1'b0;
        idex_dread = 1'b0; idex_rd = '0; ifid_rs = '0; ifid_rt = '0;
        npc_change = 1'b0; idex_halt = 1'b0; wb_halt = 1'b0;
        m_halted = 0; m_wait = 0; m_pend = 0; m_cnt = 0;
        @(posedge CLK);
        @(negedge CLK);

        // reset held two cycles, then release
        settle(); tick();
        settle();
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc", 32'(pc_wen), 0);
        tick();
        RST = 1'b0;
        settle();
        chk("run_pc", 32'(pc_wen), 1);
        chk("run_en", 32'(stage_en), 32'hF);
        chk("run_fl", 32'(stage_flush), 0);
        tick();

        // load-use: three bubbles
        idex_dread = 1'b1; idex_rd = 5'd8; ifid_rt = 5'd8; ifid_rs = 5'd1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lu_en0", 32'(stage_en[0]), 0);
            chk("lu_fl1", 32'(stage_flush[1]), 1);
            chk("lu_pc", 32'(pc_wen), 0);
            tick();
        end
        idex_dread = 1'b0;
        settle();
        chk("lu_cnt", 32'(stall_cnt), 3);
        chk("lu_done_pc", 32'(pc_wen), 1);
        tick();
        idex_dread = 1'b1; idex_rd = 5'd0; ifid_rt = 5'd0;
        settle();
        chk("lu_r0_pc", 32'(pc_wen), 1);
        tick();
        idex_dread = 1'b0;

        // data miss of five cycles
        exmem_dreq = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("miss_en", 32'(stage_en), 0);
            tick();
        end
        dhit = 1'b1;
        settle();
        chk("hit_en", 32'(stage_en), 32'hF);
        chk("hit_pc", 32'(pc_wen), 1);
        tick();
        exmem_dreq = 1'b0;
        settle();
        chk("miss_cnt", 32'(stall_cnt), 8);
        tick();

        // redirect in the second bubble cycle
        idex_dread = 1'b1; idex_rd = 5'd8; ifid_rt = 5'd8;
        settle(); tick();
        npc_change = 1'b1;
        settle();
        chk("redir_fl", 32'(stage_flush), 32'h3);
        chk("redir_pc", 32'(pc_wen), 1);
        tick();
        npc_change = 1'b0; idex_dread = 1'b0;
        settle();
        chk("redir_run", 32'(stage_en), 32'hF);
        chk("redir_pc2", 32'(pc_wen), 1);
        tick();

        // halt sequence
        idex_halt = 1'b1;
        settle();
        chk("ihalt_fl0", 32'(stage_flush[0]), 1);
        tick();
        idex_halt = 1'b0; wb_halt = 1'b1;
        settle();
        chk("whalt_h", 32'(halted), 0);
        tick();
        wb_halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ihit = 1'(i % 2); npc_change = 1'(i / 2);
            settle();
            chk("hlt_h", 32'(halted), 1);
            chk("hlt_en", 32'(stage_en), 0);
            chk("hlt_cnt", 32'(stall_cnt), 10);
            tick();
        end
        ihit = 1'b1; npc_change = 1'b0;

        // saturation of the 4-bit counter
        RST = 1'b1;
        settle(); tick();
        RST = 1'b0; exmem_dreq = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle(); tick();
        end
        settle();
        chk("sat_cnt", 32'(stall_cnt), 15);
        dhit = 1'b1;
        tick();
        exmem_dreq = 1'b0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            RST        = ($urandom_range(0, 39) == 0);
            ihit       = ($urandom_range(0, 7) != 0);
            dhit       = ($urandom_range(0, 2) != 0);
            exmem_dreq = ($urandom_range(0, 3) == 0);
            idex_dread = 1'($urandom_range(0, 1));
            idex_rd    = 5'($urandom_range(0, 3));
            ifid_rs    = 5'($urandom_range(0, 3));
            ifid_rt    = 5'($urandom_range(0, 3));
            npc_change = ($urandom_range(0, 9) == 0);
            idex_halt  = ($urandom_range(0, 19) == 0);
            wb_halt    = ($urandom_range(0, 79) == 0);
            settle(); tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard and stall controller for the multi-stage MIPS datapath. It replaces the fixed two-latch IF/ID–ID/EX hazard logic with per-latch enable and flush vectors for `NLATCH` pipeline latches. It adds a multi-cycle load-use bubble counter, a registered data-memory wait state and a terminal halt state, plus a saturating stall-cycle performance counter. It sits beside the pipeline latches and drives their enables and flushes and the PC write enable.

## Interface
- `NLATCH`, 4, number of pipeline latches; index 0 = IF/ID, `NLATCH-1` = last (MEM/WB); minimum 3
- `LU_BUBBLES`, 1, bubbles inserted per load-use hazard, 1..15
- `FLUSH_DEPTH`, 2, latches 0..`FLUSH_DEPTH-1` flushed on PC redirect, 1..`NLATCH-1`
- `REG_W`, 5, register address width
- `CNT_W`, 16, stall counter width
- `CLK` in 1: clock, rising edge
- `RST` in 1: synchronous, active-high reset
- `ihit` in 1: instruction fetch completes this cycle
- `dhit` in 1: data access completes this cycle
- `exmem_dreq` in 1: instruction in EX/MEM issues a data read or write
- `idex_dread` in 1: instruction in ID/EX is a load
- `idex_rd` in `REG_W`: load destination register
- `ifid_rs`, `ifid_rt` in `REG_W`: source registers of the instruction in IF/ID
- `npc_change` in 1: branch or jump redirect resolved this cycle
- `idex_halt` in 1: halt instruction in ID/EX
- `wb_halt` in 1: halt instruction in the last latch
- `stage_en` out `NLATCH`: latch i captures when 1
- `stage_flush` out `NLATCH`: latch i loads a bubble when 1; only acted on when `stage_en[i]`=1
- `pc_wen` out 1: PC write enable
- `halted` out 1: processor stopped
- `stall_cnt` out `CNT_W`: cycles with `pc_wen`=0 while not halted, saturating

## Operation
- FSM states: RUN, LU_STALL, DMEM_WAIT, HALTED. State and counters are registered. Outputs are combinational from state and current inputs.
- Load-use hazard (LU) is defined as: `idex_dread` & `idex_rd`≠0 & (`idex_rd`==`ifid_rs` | `idex_rd`==`ifid_rt`).
- Priority per cycle, highest first:
  1. HALTED: all `stage_en`=0, `pc_wen`=0, `halted`=1. This state is left only by `RST`.
  2. Data wait (`exmem_dreq` & !`dhit`): all `stage_en`=0, `pc_wen`=0. The next state is DMEM_WAIT. The saved state is kept so a pending LU_STALL resumes afterwards.
  3. `wb_halt`: all `stage_en`=1, flushes 0, `pc_wen`=0. The next state is HALTED.
  4. `npc_change`: all `stage_en`=1. `stage_flush[FLUSH_DEPTH-1:0]`=all 1s, plus bit 0 if `!ihit`. `pc_wen`=1. Any LU_STALL is cancelled and the bubble counter cleared; the next state is RUN.
  5. LU in RUN, or state LU_STALL: `stage_en[0]`=0, `pc_wen`=0, `stage_flush[1]`=1, latches ≥1 enabled. In RUN, the bubble counter loads `LU_BUBBLES-1`. If that value is ≠0 the next state is LU_STALL, otherwise RUN. In LU_STALL the counter decrements and returns to RUN after reaching 0.
  6. `idex_halt`: `stage_flush[0]`=1, `pc_wen`=0, all enabled.
  7. `!ihit`: `stage_flush[0]`=1, `pc_wen`=0, all enabled (fetch bubble).
  8. Otherwise: all enabled, no flush, `pc_wen`=1.
- DMEM_WAIT exits on `dhit` to the saved state. The `dhit` cycle itself applies rules 3–8.
- `stall_cnt` increments when `pc_wen`=0 and state≠HALTED and next state≠HALTED. It saturates at 2^`CNT_W`−1.

## Timing
- Reset values: state RUN, bubble counter 0, `stall_cnt`=0, `halted`=0. During the `RST` cycle, outputs are forced to `stage_en`=all 1s, `stage_flush`=all 1s, `pc_wen`=0.
- Hazard detection has zero latency: the stall is visible in the same cycle LU becomes true. A load-use hazard costs exactly `LU_BUBBLES` cycles of `stage_en[0]`=0.
- A data miss of N cycles followed by `dhit` freezes the pipe for N cycles. The pipe advances in the `dhit` cycle.
- `halted` rises in the cycle after `wb_halt` is sampled.
- If `RST` is asserted mid-LU_STALL or mid-DMEM_WAIT, the block returns to RUN on the next edge and all counters clear.

## Test plan
- Reset: hold `RST` for 2 cycles → `stall_cnt`=0, `halted`=0, `pc_wen`=0. In the first cycle after release with `ihit`=1 → `pc_wen`=1, `stage_en`=4'b1111, `stage_flush`=0.
- Load-use with `LU_BUBBLES`=3: `idex_dread`=1, `idex_rd`=8, `ifid_rt`=8 → 3 consecutive cycles with `stage_en[0]`=0, `stage_flush[1]`=1, `pc_wen`=0; `stall_cnt`=3. Repeat with `idex_rd`=0 → no stall.
- Data miss: `exmem_dreq`=1, `dhit`=0 for 5 cycles, then 1 → `stage_en`=0 for 5 cycles, then all 1s; `stall_cnt` +5.
- Redirect during LU_STALL with `FLUSH_DEPTH`=2: `npc_change`=1 in the second bubble cycle → `stage_flush`=4'b0011, `pc_wen`=1, state RUN the next cycle.
- Halt: `idex_halt`=1 → `stage_flush[0]`=1. Then `wb_halt`=1 → `halted`=1 on the next cycle, all enables 0. Further `ihit`/`npc_change` activity is ignored; `stall_cnt` is frozen.
- Saturation with `CNT_W`=4: 20 miss cycles → `stall_cnt`=15.
